// File: rtl/logicap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logicap_pkg
// Description : Shared state encoding and default widths for the capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package logicap_pkg;

    localparam int SADDR_W = 24;
    localparam int TMO_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_ABORT     = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage : logicap_pkg
`default_nettype wire

// File: rtl/capture_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority so a new run always starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : capture_sequencer
// Description : Run controller for one acquisition: arm, trigger supervision,
//               done wait, DMA drain accounting, status and completion irq.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer
    import logicap_pkg::*;
#(
    parameter int SADDR_W = logicap_pkg::SADDR_W,
    parameter int TMO_W   = logicap_pkg::TMO_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [TMO_W-1:0]   trig_timeout,
    input  logic [SADDR_W-1:0] buffer_size,
    output logic               cap_arm,
    output logic               cap_abort,
    input  logic               cap_ready,
    input  logic               cap_armed,
    input  logic               cap_triggered,
    input  logic               cap_done,
    input  logic [SADDR_W-1:0] cap_trigger_pos,
    input  logic               dma_valid,
    input  logic               dma_ready,
    input  logic               dma_last,
    output logic               busy,
    output logic [2:0]         state,
    output logic               irq,
    output logic [SADDR_W-1:0] trigger_pos,
    output logic [SADDR_W-1:0] beat_count,
    output logic               st_timeout,
    output logic               st_aborted,
    output logic               st_len_err,
    output logic               st_start_err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SADDR_W-1:0] r_exp_len;
    logic [SADDR_W-1:0] r_trigger_pos;
    logic               r_cap_arm;
    logic               r_cap_abort;
    logic               r_irq;
    logic               r_busy;
    logic               r_st_timeout;
    logic               r_st_aborted;
    logic               r_st_len_err;
    logic               r_st_start_err;

    logic               w_accept;
    logic               w_start_err_set;
    logic               w_timeout_set;
    logic               w_aborted_set;
    logic               w_len_err_set;
    logic               w_tp_latch;
    logic               w_beat;
    logic               w_reach;
    logic               w_exp_zero;
    logic               w_tmo_hit;
    logic [SADDR_W:0]   w_cnt_inc;
    logic [SADDR_W-1:0] w_beat_cnt;
    logic [TMO_W-1:0]   w_tmo_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_start_err_set = 1'b0;
        w_timeout_set   = 1'b0;
        w_aborted_set   = 1'b0;
        w_len_err_set   = 1'b0;
        w_tp_latch      = 1'b0;
        w_beat          = dma_valid && dma_ready;
        // One extra bit so a saturated count can never alias onto exp_len.
        w_cnt_inc       = {1'b0, w_beat_cnt} + {{SADDR_W{1'b0}}, 1'b1};
        w_reach         = (w_cnt_inc == {1'b0, r_exp_len});
        w_exp_zero      = (r_exp_len == '0);
        w_tmo_hit       = (trig_timeout != '0) && (w_tmo_cnt == (trig_timeout - TMO_W'(1)));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cap_ready) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ARM;
                    end else begin
                        w_start_err_set = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (stop) begin
                    w_aborted_set = 1'b1;
                    w_state_nxt   = ST_ABORT;
                end else if (cap_armed) begin
                    w_state_nxt = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                // Priority: stop, then trigger, then timeout expiry.
                if (stop) begin
                    w_aborted_set = 1'b1;
                    w_state_nxt   = ST_ABORT;
                end else if (cap_triggered) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = ST_ABORT;
                end
            end
            ST_WAIT_DONE: begin
                if (stop) begin
                    w_aborted_set = 1'b1;
                    w_state_nxt   = ST_ABORT;
                end else if (cap_done) begin
                    w_tp_latch  = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_beat && (dma_last || w_reach || w_exp_zero)) begin
                    w_len_err_set = (dma_last && !w_reach) || (!dma_last && w_reach) || w_exp_zero;
                    w_state_nxt   = ST_FINISH;
                end
            end
            ST_ABORT: begin
                if (cap_ready) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_exp_len      <= '0;
            r_trigger_pos  <= '0;
            r_cap_arm      <= 1'b0;
            r_cap_abort    <= 1'b0;
            r_irq          <= 1'b0;
            r_busy         <= 1'b0;
            r_st_timeout   <= 1'b0;
            r_st_aborted   <= 1'b0;
            r_st_len_err   <= 1'b0;
            r_st_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cap_arm   <= w_accept;
            r_cap_abort <= (w_state_nxt == ST_ABORT) && (r_state != ST_ABORT);
            r_irq       <= (w_state_nxt == ST_FINISH);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_exp_len      <= buffer_size;
                r_st_timeout   <= 1'b0;
                r_st_aborted   <= 1'b0;
                r_st_len_err   <= 1'b0;
                r_st_start_err <= 1'b0;
            end else begin
                if (w_timeout_set)   r_st_timeout   <= 1'b1;
                if (w_aborted_set)   r_st_aborted   <= 1'b1;
                if (w_len_err_set)   r_st_len_err   <= 1'b1;
                if (w_start_err_set) r_st_start_err <= 1'b1;
            end
            if (w_tp_latch) begin
                r_trigger_pos <= cap_trigger_pos;
            end
        end
    end

    sat_counter #(
        .WIDTH (SADDR_W)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_accept),
        .en      ((r_state == ST_DRAIN) && w_beat),
        .count   (w_beat_cnt)
    );

    sat_counter #(
        .WIDTH (TMO_W)
    ) u_tmo_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_accept),
        .en      (r_state == ST_WAIT_TRIG),
        .count   (w_tmo_cnt)
    );

    assign cap_arm      = r_cap_arm;
    assign cap_abort    = r_cap_abort;
    assign busy         = r_busy;
    assign state        = r_state;
    assign irq          = r_irq;
    assign trigger_pos  = r_trigger_pos;
    assign beat_count   = w_beat_cnt;
    assign st_timeout   = r_st_timeout;
    assign st_aborted   = r_st_aborted;
    assign st_len_err   = r_st_len_err;
    assign st_start_err = r_st_start_err;

endmodule : capture_sequencer
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_sequencer
// Description : Directed bench; per-run expected results queued, checked on irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    localparam int SW = 24;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, stop;
    logic [TW-1:0] trig_timeout;
    logic [SW-1:0] buffer_size;
    logic          cap_arm, cap_abort;
    logic          cap_ready, cap_armed, cap_triggered, cap_done;
    logic [SW-1:0] cap_trigger_pos;
    logic          dma_valid, dma_ready, dma_last;
    logic          busy;
    logic [2:0]    state;
    logic          irq;
    logic [SW-1:0] trigger_pos, beat_count;
    logic          st_timeout, st_aborted, st_len_err, st_start_err;

    typedef struct packed {
        logic [SW-1:0] bc;
        logic [SW-1:0] tp;
        logic [3:0]    st;   // {timeout, aborted, len_err, start_err}
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            irqs   = 0;
    int            aborts = 0;
    int            irq_snap, abort_snap;
    logic [SW-1:0] cur_tp = '0;

    capture_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .stop            (stop),
        .trig_timeout    (trig_timeout),
        .buffer_size     (buffer_size),
        .cap_arm         (cap_arm),
        .cap_abort       (cap_abort),
        .cap_ready       (cap_ready),
        .cap_armed       (cap_armed),
        .cap_triggered   (cap_triggered),
        .cap_done        (cap_done),
        .cap_trigger_pos (cap_trigger_pos),
        .dma_valid       (dma_valid),
        .dma_ready       (dma_ready),
        .dma_last        (dma_last),
        .busy            (busy),
        .state           (state),
        .irq             (irq),
        .trigger_pos     (trigger_pos),
        .beat_count      (beat_count),
        .st_timeout      (st_timeout),
        .st_aborted      (st_aborted),
        .st_len_err      (st_len_err),
        .st_start_err    (st_start_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_vec();
        return 32'({st_timeout, st_aborted, st_len_err, st_start_err});
    endfunction

    // Completion monitor: every irq pops one expected run result.
    always @(negedge clk) begin
        if (reset_n) begin
            if (cap_abort) aborts++;
            if (irq) begin
                irqs++;
                if (sb.size() == 0) begin
                    chk("irq_unexpected", 32'(irq), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("run_beat_count",  32'(beat_count),  32'(mon_e.bc));
                    chk("run_trigger_pos", 32'(trigger_pos), 32'(mon_e.tp));
                    chk("run_status",      status_vec(),     32'(mon_e.st));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] bc, input logic [SW-1:0] tp, input logic [3:0] st);
        exp_t e;
        e.bc = bc;
        e.tp = tp;
        e.st = st;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [SW-1:0] len);
        buffer_size = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        buffer_size = ~len;
        cap_ready = 1'b0;
        chk("start_arm_pulse", 32'(cap_arm), 32'd1);
        chk("start_state_arm", 32'(state),   32'd1);
        chk("start_busy",      32'(busy),    32'd1);
    endtask

    task automatic to_wait_trig();
        cap_armed = 1'b1;
        tick();
        chk("arm_pulse_end",   32'(cap_arm), 32'd0);
        chk("state_wait_trig", 32'(state),   32'd2);
    endtask

    task automatic trig();
        cap_triggered = 1'b1;
        tick();
        cap_triggered = 1'b0;
        chk("state_wait_done", 32'(state), 32'd3);
    endtask

    task automatic done(input logic [SW-1:0] tp);
        cap_trigger_pos = tp;
        cap_done = 1'b1;
        tick();
        cap_done = 1'b0;
        cap_trigger_pos = ~tp;
        cur_tp = tp;
        cap_ready = 1'b1;
        chk("state_drain", 32'(state), 32'd4);
    endtask

    // Drives n beats with random valid/ready gaps; last_at is 1-based, 0 = none.
    task automatic drain(input int n, input int last_at);
        int b = 0;
        int guard = 0;
        while (b < n && guard < 1000) begin
            dma_valid = ($urandom_range(0, 4) != 0);
            dma_ready = ($urandom_range(0, 3) != 0);
            dma_last  = dma_valid && dma_ready && (b + 1 == last_at);
            tick();
            guard++;
            if (dma_valid && dma_ready) b++;
            if (b < n) chk("drain_hold", 32'(state), 32'd4);
        end
        dma_valid = 1'b0;
        dma_ready = 1'b0;
        dma_last  = 1'b0;
        chk("drain_finish", 32'(state), 32'd6);
        chk("finish_irq",   32'(irq),   32'd1);
        cap_armed = 1'b0;
        tick();
        chk("back_idle", 32'(state), 32'd0);
        chk("irq_end",   32'(irq),   32'd0);
        chk("idle_busy", 32'(busy),  32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0;
        trig_timeout = '0; buffer_size = '0;
        cap_ready = 1'b1; cap_armed = 1'b0; cap_triggered = 1'b0; cap_done = 1'b0;
        cap_trigger_pos = '0;
        dma_valid = 1'b0; dma_ready = 1'b0; dma_last = 1'b0;
        tick(); tick(); tick();
        chk("rst_state",  32'(state),       32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_irq",    32'(irq),         32'd0);
        chk("rst_arm",    32'(cap_arm),     32'd0);
        chk("rst_abort",  32'(cap_abort),   32'd0);
        chk("rst_beats",  32'(beat_count),  32'd0);
        chk("rst_tp",     32'(trigger_pos), 32'd0);
        chk("rst_status", status_vec(),     32'd0);
        reset_n = 1'b1;
        tick();

        // Normal run: 128 beats, last on the 128th, trigger around cycle 40.
        do_start(24'd128);
        to_wait_trig();
        for (int i = 0; i < 36; i++) tick();
        chk("trig_wait_hold", 32'(state), 32'd2);
        trig();
        tick(); tick();
        chk("done_wait_hold", 32'(state), 32'd3);
        done(24'h00ABCD);
        push(24'd128, cur_tp, 4'b0000);
        drain(128, 128);

        // Trigger timeout of 20 cycles with no trigger.
        trig_timeout = 32'd20;
        do_start(24'd16);
        push(24'd0, cur_tp, 4'b1000);
        to_wait_trig();
        for (int i = 0; i < 19; i++) tick();
        chk("tmo_not_yet", 32'(state), 32'd2);
        tick();
        chk("tmo_abort_state", 32'(state),     32'd5);
        chk("tmo_abort_pulse", 32'(cap_abort), 32'd1);
        chk("tmo_status",      status_vec(),   32'h8);
        tick();
        chk("abort_hold",       32'(state),     32'd5);
        chk("abort_pulse_once", 32'(cap_abort), 32'd0);
        cap_ready = 1'b1;
        tick();
        chk("abort_finish", 32'(state), 32'd6);
        cap_armed = 1'b0;
        tick();
        chk("abort_idle", 32'(state), 32'd0);

        // Stop in WAIT_DONE.
        trig_timeout = '0;
        do_start(24'd16);
        push(24'd0, cur_tp, 4'b0100);
        to_wait_trig();
        trig();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_abort_state", 32'(state),      32'd5);
        chk("stop_abort_pulse", 32'(cap_abort),  32'd1);
        chk("stop_beats",       32'(beat_count), 32'd0);
        cap_ready = 1'b1;
        tick();
        chk("stop_finish", 32'(state), 32'd6);
        cap_armed = 1'b0;
        tick();

        // Stop in DRAIN is ignored.
        do_start(24'd4);
        to_wait_trig();
        trig();
        done(24'h001234);
        push(24'd4, cur_tp, 4'b0000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("drain_stop_ignored", 32'(state),     32'd4);
        chk("drain_no_abort",     32'(cap_abort), 32'd0);
        drain(4, 4);

        // Early last on beat 5 of 8.
        do_start(24'd8);
        to_wait_trig();
        trig();
        done(24'h000055);
        push(24'd5, cur_tp, 4'b0010);
        drain(5, 5);

        // 8 beats with no last.
        do_start(24'd8);
        to_wait_trig();
        trig();
        done(24'h000088);
        push(24'd8, cur_tp, 4'b0010);
        drain(8, 0);

        // Zero expected length finishes on the first beat.
        do_start(24'd0);
        to_wait_trig();
        trig();
        done(24'hFFFFFE);
        push(24'd1, cur_tp, 4'b0010);
        drain(1, 0);

        // Start refused while capture engine not ready.
        cap_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nr_state",     32'(state),        32'd0);
        chk("nr_busy",      32'(busy),         32'd0);
        chk("nr_arm",       32'(cap_arm),      32'd0);
        chk("nr_start_err", 32'(st_start_err), 32'd1);
        cap_ready = 1'b1;
        do_start(24'd16);
        chk("start_err_cleared", 32'(st_start_err), 32'd0);
        push(24'd0, cur_tp, 4'b0100);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_state", 32'(state),        32'd1);
        chk("busy_start_noerr", 32'(st_start_err), 32'd0);
        chk("busy_start_noarm", 32'(cap_arm),      32'd0);
        to_wait_trig();
        stop = 1'b1;
        cap_triggered = 1'b1;
        tick();
        stop = 1'b0;
        cap_triggered = 1'b0;
        chk("stop_beats_trig", 32'(state), 32'd5);
        cap_ready = 1'b1;
        tick();
        chk("stop_trig_finish", 32'(state), 32'd6);
        cap_armed = 1'b0;
        tick();

        // Trigger on the timeout-expiry cycle wins.
        trig_timeout = 32'd3;
        do_start(24'd2);
        to_wait_trig();
        tick(); tick();
        chk("tt_hold", 32'(state), 32'd2);
        trig();
        chk("tt_no_timeout", 32'(st_timeout), 32'd0);
        done(24'h0FF00F);
        push(24'd2, cur_tp, 4'b0000);
        drain(2, 2);

        // Asynchronous reset in WAIT_TRIG.
        trig_timeout = '0;
        irq_snap   = irqs;
        abort_snap = aborts;
        do_start(24'd4);
        to_wait_trig();
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("ar_state",  32'(state),       32'd0);
        chk("ar_busy",   32'(busy),        32'd0);
        chk("ar_irq",    32'(irq),         32'd0);
        chk("ar_abort",  32'(cap_abort),   32'd0);
        chk("ar_beats",  32'(beat_count),  32'd0);
        chk("ar_tp",     32'(trigger_pos), 32'd0);
        chk("ar_status", status_vec(),     32'd0);
        cap_armed = 1'b0;
        cap_ready = 1'b1;
        #2;
        reset_n = 1'b1;
        tick(); tick();
        chk("ar_after_state", 32'(state), 32'd0);
        chk("ar_no_irq",      32'(irqs),   32'(irq_snap));
        chk("ar_no_abort",    32'(aborts), 32'(abort_snap));

        chk("total_irqs",   32'(irqs),      32'd9);
        chk("total_aborts", 32'(aborts),    32'd3);
        chk("sb_empty",     32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_capture_sequencer
`default_nettype wire
